ahb_master_arbiter: RTL
=======================

# ahb_master_arbiter

Shares one AHB5-Lite master port among NUM_REQ local requesters, each presenting single-transfer commands over a valid/ready interface. A round-robin arbiter selects one command, the block sequences its address and data phases on the bus, honours HREADY wait states and two-cycle ERROR responses, and returns read data or an error to the winning requester. It sits between DMA/CPU-side command sources and the AHB slave fabric driven by the ahb agent.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- HPROT_VAL, 4'b0011: constant HPROT driven on every transfer (non-cacheable, privileged, data).
- hclk  in  1  bus clock; all logic on its rising edge.
- hreset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  command pending, one bit per requester.
- req_ready  out  NUM_REQ  command accepted this cycle (one-hot or zero).
- req_addr  in  NUM_REQ*32  byte address; slice i belongs to requester i.
- req_write  in  NUM_REQ  1 = write.
- req_size  in  NUM_REQ*3  HSIZE encoding; only 0..2 are legal.
- req_wdata  in  NUM_REQ*32  write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data (shared; qualified by rsp_valid).
- rsp_err  out  1  1 = slave ERROR or rejected command (qualified by rsp_valid).
- busy  out  1  transfer in flight (state != IDLE).
- haddr, htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hprot[3:0], hsel, hwdata[31:0]  out  AHB master outputs.
- hrdata[31:0], hready, hresp[1:0]  in  AHB slave responses (hresp[0] = ERROR).

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any req_valid, the round-robin winner is the first set bit at or after (last_grant+1) mod NUM_REQ. Assert req_ready[winner] combinationally in the same cycle. Capture addr, write, size and wdata, record owner, update last_grant, then go to ADDR.
- Illegal command: size > 2, or addr not aligned to size. Still granted (req_ready), but no bus transfer. Next cycle: rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0. FSM stays in IDLE.
- ADDR: drive the bus:
  - haddr = captured addr; htrans = NONSEQ (2'b10); hsel = 1; hwrite; hsize.
  - hburst = SINGLE (0); hprot = HPROT_VAL.
  - Address phase ends at the first edge with hready=1, then go to DATA.
- DATA:
  - htrans = IDLE, hsel = 0, haddr held.
  - hwdata = captured wdata (writes); 0 for reads.
  - Ends at the first edge with hready=1. Capture hrdata (reads) and hresp[0], then go to IDLE.
  - Next cycle: rsp_valid[owner]=1, rsp_err = captured hresp[0], rsp_rdata = hrdata for reads, 0 for writes.
- ERROR response: the first ERROR cycle (hready=0, hresp=1) is treated as a wait state. Only the hready=1 edge completes the transfer. No pipelined transfer is ever outstanding, so no cancellation is needed.
- Transfers never overlap. The arbiter in IDLE may grant in the same cycle that rsp_valid pulses.
- Inputs of unselected requesters are ignored. A requester may drop req_valid without penalty when it is not granted.

## Timing
- Reset (async assert, sync release), all outputs 0:
  - haddr, htrans (IDLE), hwrite, hsize, hburst, hprot, hsel, hwdata.
  - req_ready, rsp_valid, rsp_rdata, rsp_err, busy.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Zero-wait-state legal transfer:
  - grant at cycle 0;
  - address phase at cycle 1;
  - data phase at cycle 2;
  - rsp_valid at cycle 3, together with the next grant.
  - Minimum 3 cycles per transfer.
- Each hready=0 cycle extends the current phase by one cycle. There is no upper bound and no timeout.
- Reset mid-transfer: the bus returns immediately to IDLE/hsel=0. The in-flight response is discarded and no rsp_valid is issued.
- Simultaneous req_valid on all requesters: grants rotate strictly 0,1,…,NUM_REQ-1,0.
- last_grant wrap: NUM_REQ-1 → 0.

## Structure
- Shared package ahb_pkg:
  - htrans_t (IDLE, BUSY, NONSEQ, SEQ), hburst_t, hsize_t;
  - HRESP_OKAY/HRESP_ERROR;
  - arbiter state enum (IDLE, ADDR, DATA).
- Sub-module ahb_rr_arbiter: parameter N, inputs req[N] and last_grant, outputs a one-hot gnt and an encoded index. It is purely combinational; the pointer register lives in the top module.

## Test plan
- Single read, requester 0, addr 0x1000, size 2, zero wait states → htrans=NONSEQ in cycle 1, rsp_valid[0] in cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write from requester 1, wdata 0xA5A5_0001, slave inserts 3 wait states in the data phase → hwdata stable for 4 cycles, rsp_valid[1] at cycle 6, rsp_err=0.
- Two-cycle ERROR on a read → first cycle ignored, rsp_err=1 at completion, and the bus returns to IDLE.
- Both requesters continuously valid for 6 transfers → grant order 0,1,0,1,0,1, with no two grants closer than 3 cycles.
- Misaligned command (addr 0x1002, size 2), then size 3 → both granted, rsp_err=1 the next cycle, htrans stays IDLE throughout.
- hreset asserted during the DATA phase of a read → all outputs 0 asynchronously, and no rsp_valid after release. The next request gets requester 0 priority.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB5-Lite encodings, response codes, arbiter FSM states and the
// command legality rule used by the master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Sizes above a word and addresses not aligned to the size are rejected.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    cmd_legal = 1'b1;
      3'd1:    cmd_legal = ~addr_lo[0];
      3'd2:    cmd_legal = (addr_lo == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Requester command/response bundle plus the AHB5-Lite master port, with the
// arbiter's view (master) and the environment's view (slave).
interface ahb_master_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import ahb_pkg::*;

  // Command handshake: a command on requester i transfers in a cycle where
  // req_valid[i] and req_ready[i] are both high; req_ready is one-hot or zero
  // and may depend combinationally on req_valid. The response is a single
  // rsp_valid[i] pulse; rsp_rdata/rsp_err mean nothing outside that pulse.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0][2:0]  req_size;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic                     busy;

  logic [31:0] haddr;
  htrans_t     htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hsel;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  arb_state_t  dbg_state;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
    input  hrdata, hready, hresp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hsel, hwdata,
    output dbg_state
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata,
    output hrdata, hready, hresp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hsel, hwdata,
    input  dbg_state
  );

endinterface

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after
// (last_grant + 1) mod N wins. The pointer register lives in the caller.
module ahb_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB5-Lite master port among NUM_REQ requesters: round-robin grant,
// one single transfer at a time through address and data phases.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic                  hclk,
  input logic                  hreset,
  ahb_master_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [2:0]         size_q, size_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;

  ahb_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .idx_o        (gnt_idx)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      owner_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      size_q       <= size_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    size_d        = size_q;
    rsp_valid_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = '0;
    bus.req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid && !hreset) begin
          bus.req_ready = gnt;
          last_grant_d  = gnt_idx;
          owner_d       = gnt_idx;
          addr_d        = bus.req_addr[gnt_idx];
          wdata_d       = bus.req_wdata[gnt_idx];
          write_d       = bus.req_write[gnt_idx];
          size_d        = bus.req_size[gnt_idx];
          // Rejected commands are answered next cycle without touching the bus.
          if (cmd_legal(bus.req_size[gnt_idx], bus.req_addr[gnt_idx][1:0])) begin
            state_d = ST_ADDR;
          end else begin
            rsp_valid_d = gnt;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (bus.hready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // The first ERROR cycle has hready low and simply waits here.
        if (bus.hready) begin
          state_d              = ST_IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = ((bus.hresp & HRESP_ERROR) != HRESP_OKAY);
          rsp_rdata_d          = write_q ? 32'h0 : bus.hrdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.haddr  = '0;
    bus.htrans = HTRANS_IDLE;
    bus.hwrite = 1'b0;
    bus.hsize  = '0;
    bus.hburst = HBURST_SINGLE;
    bus.hprot  = '0;
    bus.hsel   = 1'b0;
    bus.hwdata = '0;
    case (state_q)
      ST_ADDR: begin
        bus.haddr  = addr_q;
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = write_q;
        bus.hsize  = size_q;
        bus.hprot  = HPROT_VAL;
        bus.hsel   = 1'b1;
      end
      ST_DATA: begin
        bus.haddr  = addr_q;
        bus.hwdata = write_q ? wdata_q : 32'h0;
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;

endmodule
